// File: rtl/tr_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tr_sched_pkg
//  Description : Shared types and helpers for the transducer update scheduler.
//                Holds the scheduler state encoding and the load-length
//                function derived from the transducer count.
//  Revision    : 1.0 - initial release
// ============================================================================
package tr_sched_pkg;

    // Scheduler state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

    // Width and ceiling of the saturating drop counter
    localparam int         DROP_CNT_W   = 8;
    localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

    // Number of cycles the downstream loader needs for a full parameter load:
    // two words per transducer plus a fixed pipeline overhead.
    function automatic int calc_load_cycles(input int trans_num);
        return (2 * trans_num) + 5;
    endfunction

endpackage : tr_sched_pkg
`default_nettype wire

// File: rtl/tr_update_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tr_update_scheduler
//  Description : Arbitrates CPU and sync-tick update requests into single
//                load strobes for the transducer-parameter loader. Requests
//                arriving while a load runs (or while the CPU holds the BRAM)
//                are coalesced into one pending request; further requests are
//                counted as drops. Also flags BRAM writes that overlap a load.
//  Revision    : 1.0 - initial release
// ============================================================================
import tr_sched_pkg::*;

module tr_update_scheduler #(
    parameter int TRANS_NUM = 249
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ_CPU,
    input  logic       REQ_SYNC,
    input  logic       SYNC_EN,
    input  logic       HOLD,
    input  logic       CLR_STAT,
    output logic       UPDATE,
    output logic       BUSY,
    output logic       PENDING,
    output logic       LOAD_DONE,
    output logic [7:0] DROP_CNT,
    output logic       COLLISION
);

    localparam int LOAD_CYCLES = calc_load_cycles(TRANS_NUM);
    localparam int CNT_W       = $clog2(LOAD_CYCLES + 1);

    // Counter value seen on the final LOAD cycle
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(LOAD_CYCLES - 1);

    sched_state_e       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic [7:0]         drop_q, drop_d;
    logic               coll_q, coll_d;
    logic               update_q, update_d;
    logic               done_q, done_d;

    logic               w_req;
    logic               w_issue;
    logic               w_drop_inc;
    logic               w_coll_set;

    // A CPU and a sync request in the same cycle merge into one request
    assign w_req = REQ_CPU | (REQ_SYNC & SYNC_EN);

    // Start a load from IDLE when something is waiting and the BRAM is free;
    // a fresh request coinciding with a pending one is absorbed here.
    assign w_issue = (state_q == ST_IDLE) & (w_req | pend_q) & ~HOLD;

    // A request lost because one is already pending and it is not issuing now
    assign w_drop_inc = w_req & pend_q & ~w_issue;

    // BRAM being rewritten while the loader is reading it
    assign w_coll_set = HOLD & ((state_q == ST_ISSUE) | (state_q == ST_LOAD));

    // Next-state, load counter and registered strobe decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        update_d = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_issue) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == c_CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes are flopped so they come straight off a register
        update_d = (state_d == ST_ISSUE);
        done_d   = (state_d == ST_DONE);
    end

    // Pending flag and statistics; set/increment wins over the clear
    always_comb begin
        pend_d = pend_q;
        drop_d = drop_q;
        coll_d = coll_q;

        if (w_issue) begin
            pend_d = 1'b0;
        end else if (w_req) begin
            pend_d = 1'b1;
        end

        if (w_drop_inc) begin
            if (drop_q != DROP_CNT_MAX) begin
                drop_d = drop_q + 1'b1;
            end
        end else if (CLR_STAT) begin
            drop_d = '0;
        end

        if (w_coll_set) begin
            coll_d = 1'b1;
        end else if (CLR_STAT) begin
            coll_d = 1'b0;
        end
    end

    // State and status registers; reset discards any request in that cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            drop_q   <= '0;
            coll_q   <= 1'b0;
            update_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            drop_q   <= drop_d;
            coll_q   <= coll_d;
            update_q <= update_d;
            done_q   <= done_d;
        end
    end

    assign UPDATE    = update_q;
    assign LOAD_DONE = done_q;
    assign BUSY      = (state_q != ST_IDLE);
    assign PENDING   = pend_q;
    assign DROP_CNT  = drop_q;
    assign COLLISION = coll_q;

endmodule : tr_update_scheduler
`default_nettype wire

// File: tb/tb_tr_update_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tr_update_scheduler
//  Description : Self-checking bench for tr_update_scheduler. A timestamp
//                based reference model (time since last issue, pending flag,
//                statistics) predicts every output each cycle; directed
//                scenarios plus a long randomized run drive the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tr_update_scheduler;

    localparam int TN = 249;
    localparam int LC = 2 * TN + 5;

    logic       clk = 1'b0;
    logic       rst, req_cpu, req_sync, sync_en, hold, clr_stat;
    logic       upd, busy, pend, ldone, coll;
    logic [7:0] drop;

    always #5 clk = ~clk;

    tr_update_scheduler #(.TRANS_NUM(TN)) dut (
        .CLK       (clk),
        .RST       (rst),
        .REQ_CPU   (req_cpu),
        .REQ_SYNC  (req_sync),
        .SYNC_EN   (sync_en),
        .HOLD      (hold),
        .CLR_STAT  (clr_stat),
        .UPDATE    (upd),
        .BUSY      (busy),
        .PENDING   (pend),
        .LOAD_DONE (ldone),
        .DROP_CNT  (drop),
        .COLLISION (coll)
    );

    int cyc    = 0;
    int n_cmp  = 0;
    int n_err  = 0;

    // Reference model: a load is described only by the cycle of its strobe
    bit m_valid = 1'b0;
    bit m_has   = 1'b0;
    int m_issue = 0;
    bit m_pend  = 1'b0;
    int m_drop  = 0;
    bit m_coll  = 1'b0;

    int last_upd = -1;
    int upd_q[$];
    int done_q[$];

    bit rnd_en   = 1'b0;
    int rnd_hold = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Compare this cycle's outputs, advance the model with the applied inputs,
    // then move to the next cycle (sampling 1 time unit after the edge).
    task automatic tick(input int c);
        int  e;
        bit  e_busy, e_upd, e_done, r;
        bit  d_inc;
        e      = cyc - m_issue;
        e_busy = m_has && (e >= 0) && (e <= LC + 1);
        e_upd  = m_has && (e == 0);
        e_done = m_has && (e == LC + 1);

        if (m_valid) begin
            check_val("update",    upd,   e_upd);
            check_val("busy",      busy,  e_busy);
            check_val("load_done", ldone, e_done);
            check_val("pending",   pend,  m_pend);
            check_val("drop_cnt",  drop,  m_drop);
            check_val("collision", coll,  m_coll);
        end

        if (upd === 1'b1) begin
            if (last_upd >= 0)
                check_val("upd_spacing", (cyc - last_upd) >= (LC + 3), 1);
            last_upd = cyc;
            upd_q.push_back(c);
        end
        if (ldone === 1'b1)
            done_q.push_back(c);

        r = req_cpu | (req_sync & sync_en);
        if (rst) begin
            m_valid  = 1'b1;
            m_has    = 1'b0;
            m_pend   = 1'b0;
            m_drop   = 0;
            m_coll   = 1'b0;
            last_upd = -1;
        end else if (m_valid) begin
            d_inc = 1'b0;
            if (!e_busy && (r || m_pend) && !hold) begin
                m_has   = 1'b1;
                m_issue = cyc + 1;
                m_pend  = 1'b0;
            end else if (r) begin
                if (m_pend) d_inc = 1'b1;
                m_pend = 1'b1;
            end
            if (d_inc)
                m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            else if (clr_stat)
                m_drop = 0;
            if (hold && e_busy && (e <= LC))
                m_coll = 1'b1;
            else if (clr_stat)
                m_coll = 1'b0;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Run one scenario; cycles 0-1 are always reset
    task automatic run_scn(input int id, input int len);
        upd_q.delete();
        done_q.delete();
        for (int c = 0; c < len; c++) begin
            rst      = (c < 2);
            req_cpu  = 1'b0;
            req_sync = 1'b0;
            sync_en  = 1'b0;
            hold     = 1'b0;
            clr_stat = 1'b0;
            case (id)
                0: req_cpu = (c == 10);
                1: begin
                    req_cpu = (c == 10);
                    hold    = (c >= 5) && (c <= 20);
                end
                2: begin
                    sync_en  = 1'b1;
                    req_cpu  = (c == 10);
                    req_sync = (c == 100) || (c == 200);
                end
                3: begin
                    sync_en  = (c < 300);
                    req_cpu  = (c == 10);
                    req_sync = (c == 10) || (c == 600);
                end
                4: begin
                    req_cpu  = (c == 10);
                    hold     = (c == 300);
                    clr_stat = (c == 600);
                end
                5: req_cpu = (c == 10) || ((c >= 12) && (c < 312));
                6: begin
                    req_cpu = (c == 10);
                    rst     = (c < 2) || (c == 200);
                end
                default: begin
                    rst = (c < 2) || ($urandom_range(0, 2999) == 0);
                    if ($urandom_range(0, 3) == 0)
                        req_cpu = ($urandom_range(0, 29) == 0);
                    else
                        req_cpu = ($urandom_range(0, 299) == 0);
                    req_sync = ($urandom_range(0, 179) == 0);
                    if ($urandom_range(0, 399) == 0) rnd_en = ~rnd_en;
                    sync_en = rnd_en;
                    if (rnd_hold > 0) begin
                        hold = 1'b1;
                        rnd_hold--;
                    end else if ($urandom_range(0, 59) == 0) begin
                        rnd_hold = $urandom_range(1, 30);
                    end
                    clr_stat = ($urandom_range(0, 249) == 0);
                end
            endcase
            tick(c);
        end
    endtask

    initial begin
        rst = 1'b1; req_cpu = 1'b0; req_sync = 1'b0;
        sync_en = 1'b0; hold = 1'b0; clr_stat = 1'b0;
        @(posedge clk);
        #1;

        // Basic latency
        run_scn(0, 530);
        check_val("s0_upd_n",  upd_q.size(), 1);
        check_val("s0_upd_t",  (upd_q.size()  > 0) ? upd_q[0]  : -1, 11);
        check_val("s0_done_n", done_q.size(), 1);
        check_val("s0_done_t", (done_q.size() > 0) ? done_q[0] : -1, 515);

        // Request under HOLD waits for release
        run_scn(1, 40);
        check_val("s1_upd_t", (upd_q.size() > 0) ? upd_q[0] : -1, 22);

        // Coalescing and one drop
        run_scn(2, 1030);
        check_val("s2_upd_n",  upd_q.size(), 2);
        check_val("s2_upd2_t", (upd_q.size() > 1) ? upd_q[1] : -1, 517);
        check_val("s2_drop",   drop, 1);

        // Simultaneous requests merge; disabled sync ignored
        run_scn(3, 700);
        check_val("s3_upd_n", upd_q.size(), 1);
        check_val("s3_drop",  drop, 0);

        // Collision and clear
        run_scn(4, 620);
        check_val("s4_done_t", (done_q.size() > 0) ? done_q[0] : -1, 515);
        check_val("s4_coll",   coll, 0);

        // Drop counter saturation
        run_scn(5, 330);
        check_val("s5_drop", drop, 255);
        check_val("s5_pend", pend, 1);

        // Reset mid-load
        run_scn(6, 300);
        check_val("s6_done_n", done_q.size(), 0);
        check_val("s6_busy",   busy, 0);

        // Randomized traffic
        run_scn(7, 8000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_tr_update_scheduler
`default_nettype wire

// File: doc/tr_update_scheduler.md
TR_UPDATE_SCHEDULER -- requirements
Module: tr_update_scheduler

Interface
REQ-001 Parameter TRANS_NUM, default 249, number of transducers served by the downstream transducer-parameter loader.
REQ-002 CLK  input  1  system clock; one clock only; all logic on posedge CLK.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 REQ_CPU  input  1  single-cycle update request from the CPU register decoder.
REQ-005 REQ_SYNC  input  1  single-cycle update request from the sync/timing tick.
REQ-006 SYNC_EN  input  1  level; REQ_SYNC is ignored while low.
REQ-007 HOLD  input  1  level; high while the CPU is writing the transducer BRAM.
REQ-008 CLR_STAT  input  1  single-cycle clear of DROP_CNT and COLLISION.
REQ-009 UPDATE  output  1  single-cycle registered load strobe to the loader's UPDATE input.
REQ-010 BUSY  output  1  high whenever state is not IDLE.
REQ-011 PENDING  output  1  a request is latched and not yet issued.
REQ-012 LOAD_DONE  output  1  single-cycle pulse; loader has returned to idle.
REQ-013 DROP_CNT  output  8  saturating count of requests lost to coalescing.
REQ-014 COLLISION  output  1  sticky; HOLD was seen high while a load was in progress.

Function
REQ-015 Effective request req = REQ_CPU | (REQ_SYNC & SYNC_EN); simultaneous CPU and sync requests count as one request and cause no drop.
REQ-016 States: IDLE, ISSUE, LOAD, DONE.
REQ-017 IDLE: if (req | PENDING) & !HOLD, go to ISSUE and clear PENDING; if req & HOLD, set PENDING and stay in IDLE.
REQ-018 ISSUE: UPDATE=1 for exactly this cycle; load counter set to 0; go to LOAD.
REQ-019 LOAD: counter increments each cycle; after LOAD_CYCLES = 2*TRANS_NUM+5 cycles in LOAD (counter == LOAD_CYCLES-1), go to DONE.
REQ-020 DONE: LOAD_DONE=1 for this cycle; go to IDLE.
REQ-021 Latency: req at cycle r with HOLD low in IDLE gives UPDATE at r+1, LOAD at r+2..r+1+LOAD_CYCLES, LOAD_DONE at r+2+LOAD_CYCLES, IDLE at r+3+LOAD_CYCLES.
REQ-022 req in ISSUE, LOAD or DONE with PENDING low sets PENDING; a pending request issues on the first IDLE cycle with HOLD low (UPDATE one cycle later).
REQ-023 req in any state while PENDING is already high leaves PENDING set and increments DROP_CNT; DROP_CNT saturates at 255.
REQ-024 req in IDLE with PENDING high and HOLD low is absorbed by the issue and does not count as a drop.
REQ-025 HOLD high in ISSUE or LOAD sets COLLISION; the load is not aborted.
REQ-026 CLR_STAT zeroes DROP_CNT and COLLISION; an increment or set in the same cycle takes priority over the clear.
REQ-027 UPDATE is never asserted in two cycles less than LOAD_CYCLES+3 apart.
REQ-028 The load counter is wide enough for LOAD_CYCLES, computed as $clog2(LOAD_CYCLES+1) bits.

Reset
REQ-029 RST forces IDLE, counter=0, UPDATE=0, BUSY=0, PENDING=0, LOAD_DONE=0, DROP_CNT=0, COLLISION=0.
REQ-030 RST mid-LOAD aborts without a LOAD_DONE pulse; requests present in the reset cycle are discarded.

Structure
REQ-031 Package tr_sched_pkg holds the state enum (logic [1:0]) and the function computing LOAD_CYCLES from TRANS_NUM.
REQ-032 Single flat module; the saturating 8-bit counter is inline and there is no sub-module.

Verification
REQ-033 TRANS_NUM=249, REQ_CPU at cycle 10, HOLD=0 -> UPDATE at 11, BUSY from 11, LOAD_DONE at 515, BUSY low at 516.
REQ-034 REQ_CPU at 10 with HOLD=1 over cycles 5-20 -> PENDING set at 11, UPDATE at 22, PENDING low at 22.
REQ-035 REQ_CPU at 10, REQ_SYNC (SYNC_EN=1) at 100 and 200 -> PENDING set at 101, DROP_CNT=1 at 201, second UPDATE at 517.
REQ-036 REQ_CPU and REQ_SYNC both at 10 -> one UPDATE at 11, DROP_CNT=0; REQ_SYNC with SYNC_EN=0 -> no UPDATE.
REQ-037 HOLD pulse at 300 during load -> COLLISION=1 from 301, LOAD_DONE still at 515; CLR_STAT at 600 -> COLLISION=0 at 601.
REQ-038 300 coalesced requests during one load -> DROP_CNT=255 saturated; RST at 200 mid-load -> all outputs 0 at 201, no LOAD_DONE.
